// File: rtl/handshake_responder_pkg.sv
// Shared types and constants for the four-phase handshake responder.
package handshake_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam int unsigned ACK_DLY_MIN = 1;
    localparam int unsigned ACK_DLY_MAX = 2;
    localparam int unsigned DLY_W       = $clog2(ACK_DLY_MAX);

endpackage

// File: rtl/handshake_responder_fifo.sv
// Capture buffer: power-of-two circular FIFO with occupancy count and registered valid.
module resp_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_ok_c;
    logic              pop_ok_c;

    // A full buffer only accepts a push when the head leaves on the same edge.
    assign pop_ok_c  = pop & (count != '0);
    assign push_ok_c = push & ((count != CNT_W'(DEPTH)) | pop_ok_c);

    always_comb begin
        count_nxt = count;
        if (push_ok_c && !pop_ok_c) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    // Storage is not reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign out_data = mem[rd_ptr];

endmodule

// File: rtl/handshake_responder.sv
// Four-phase handshake responder: captures one payload per req pulse into a buffer.
module handshake_responder
    import handshake_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ACK_DLY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       ack,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned DLY_CLAMP = (ACK_DLY < ACK_DLY_MIN) ? ACK_DLY_MIN :
                                        (ACK_DLY > ACK_DLY_MAX) ? ACK_DLY_MAX : ACK_DLY;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DLY_CLAMP - 1);

    state_e           state;
    state_e           state_nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic [DLY_W-1:0] dly_cnt_nxt;
    logic             ack_nxt;
    logic             err_nxt;
    logic             push_c;
    logic             pop_c;
    logic             can_push_c;

    assign pop_c      = out_valid & out_ready;
    assign can_push_c = (count < CNT_W'(DEPTH)) | pop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            ack       <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_cnt_nxt;
            ack       <= ack_nxt;
            proto_err <= err_nxt;
        end
    end

    // Room is reserved in IDLE; pops can only free more space before the push lands.
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        ack_nxt     = ack;
        err_nxt     = proto_err;
        push_c      = 1'b0;
        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (req && can_push_c) begin
                    state_nxt   = DELAY;
                    dly_cnt_nxt = DLY_LOAD;
                end
            end
            DELAY: begin
                if (!req) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end else if (dly_cnt == '0) begin
                    state_nxt = ACK;
                    ack_nxt   = 1'b1;
                    push_c    = 1'b1;
                end else begin
                    dly_cnt_nxt = dly_cnt - DLY_W'(1);
                end
            end
            ACK: begin
                if (!req) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
            end
        endcase
    end

    resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (req_data),
        .pop       (pop_c),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count)
    );

endmodule
